// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse keyer and its LUT.
// MORSE_TX_WORD_GAP_EN adds the WORD state used for inter-word spacing.
package morse_pkg;

  localparam int unsigned PAT_W = 16;
  localparam logic [4:0] CODE_SPACE      = 5'd26;
  localparam logic [4:0] CODE_MAX_LETTER = 5'd25;

`ifdef MORSE_TX_WORD_GAP_EN
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_WORD} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND} state_t;
`endif

  // Index of the most significant set bit; 0 when the pattern is empty.
  function automatic logic [3:0] lead_one_idx(input logic [PAT_W-1:0] p);
    logic [3:0] r;
    r = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      if (p[i]) r = 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/morse_tx_if.sv
// Character request handshake between a character source and the keyer.
interface morse_tx_if;
  logic       char_valid;
  logic [4:0] char_code;
  logic       char_ready;

  modport master (output char_valid, output char_code, input char_ready);
  modport slave  (input char_valid, input char_code, output char_ready);
endinterface

// File: rtl/morse_lut.sv
// Letter code to right-aligned unit pattern (dot=10, dash=1110).
// Purely combinational so a decoder can reuse it.
module morse_lut
  import morse_pkg::*;
(
  input  logic [4:0]       char_code,
  output logic [PAT_W-1:0] pattern,
  output logic             is_letter
);

  // Symbol presence mask and dash flags, first symbol at bit 3.
  logic [3:0] msk;
  logic [3:0] dsh;

  always_comb begin
    msk = '0;
    dsh = '0;
    case (char_code)
      5'd0:  {msk, dsh} = {4'b1100, 4'b0100};
      5'd1:  {msk, dsh} = {4'b1111, 4'b1000};
      5'd2:  {msk, dsh} = {4'b1111, 4'b1010};
      5'd3:  {msk, dsh} = {4'b1110, 4'b1000};
      5'd4:  {msk, dsh} = {4'b1000, 4'b0000};
      5'd5:  {msk, dsh} = {4'b1111, 4'b0010};
      5'd6:  {msk, dsh} = {4'b1110, 4'b1100};
      5'd7:  {msk, dsh} = {4'b1111, 4'b0000};
      5'd8:  {msk, dsh} = {4'b1100, 4'b0000};
      5'd9:  {msk, dsh} = {4'b1111, 4'b0111};
      5'd10: {msk, dsh} = {4'b1110, 4'b1010};
      5'd11: {msk, dsh} = {4'b1111, 4'b0100};
      5'd12: {msk, dsh} = {4'b1100, 4'b1100};
      5'd13: {msk, dsh} = {4'b1100, 4'b1000};
      5'd14: {msk, dsh} = {4'b1110, 4'b1110};
      5'd15: {msk, dsh} = {4'b1111, 4'b0110};
      5'd16: {msk, dsh} = {4'b1111, 4'b1101};
      5'd17: {msk, dsh} = {4'b1110, 4'b0100};
      5'd18: {msk, dsh} = {4'b1110, 4'b0000};
      5'd19: {msk, dsh} = {4'b1000, 4'b1000};
      5'd20: {msk, dsh} = {4'b1110, 4'b0010};
      5'd21: {msk, dsh} = {4'b1111, 4'b0001};
      5'd22: {msk, dsh} = {4'b1110, 4'b0110};
      5'd23: {msk, dsh} = {4'b1111, 4'b1001};
      5'd24: {msk, dsh} = {4'b1111, 4'b1011};
      5'd25: {msk, dsh} = {4'b1111, 4'b1100};
      default: {msk, dsh} = '0;
    endcase
  end

  always_comb begin
    logic [3:0] m;
    logic [3:0] d;
    pattern = '0;
    m = msk;
    d = dsh;
    for (int unsigned i = 0; i < 4; i++) begin
      if (m[3]) begin
        if (d[3]) pattern = {pattern[PAT_W-5:0], 4'b1110};
        else      pattern = {pattern[PAT_W-3:0], 2'b10};
      end
      m = {m[2:0], 1'b0};
      d = {d[2:0], 1'b0};
    end
  end

  assign is_letter = (char_code <= CODE_MAX_LETTER);

endmodule

// File: rtl/morse_tx.sv
// Serial Morse keyer: one unit of key_out per newclk edge.
// Define MORSE_TX_WORD_GAP_EN to treat code 26 as a word space.
module morse_tx
  import morse_pkg::*;
(
  input  logic             newclk,
  input  logic             reset,
  morse_tx_if.slave        chr,
  output logic             key_out,
  output logic             busy,
  output logic [PAT_W-1:0] pattern_out,
  output logic             err
);

  state_t           state;
  logic [4:0]       code_q;
  logic [PAT_W-1:0] shreg;
  logic [3:0]       idx;
  logic [3:0]       lead;
  logic             last;
  logic [PAT_W-1:0] lut_pat;
  logic             lut_letter;
  logic             space_req;
`ifdef MORSE_TX_WORD_GAP_EN
  logic             wcnt;
`endif

  morse_lut u_lut (
    .char_code (chr.char_code),
    .pattern   (lut_pat),
    .is_letter (lut_letter)
  );

`ifdef MORSE_TX_WORD_GAP_EN
  assign space_req = (chr.char_code == CODE_SPACE);
`else
  assign space_req = 1'b0;
`endif

  assign lead           = lead_one_idx(pattern_out);
  assign chr.char_ready = (state == ST_IDLE);
  assign busy           = (state != ST_IDLE);

  // LOAD already presents the leading bit so SEND ends on the trailing 0,
  // giving the 3-unit inter-letter gap with IDLE and the next LOAD.
  always_ff @(posedge newclk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      key_out     <= 1'b0;
      pattern_out <= '0;
      err         <= 1'b0;
      code_q      <= '0;
      shreg       <= '0;
      idx         <= '0;
      last        <= 1'b0;
`ifdef MORSE_TX_WORD_GAP_EN
      wcnt        <= 1'b0;
`endif
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          key_out <= 1'b0;
          if (chr.char_valid) begin
            code_q <= chr.char_code;
            state  <= ST_LOAD;
            if (lut_letter)      pattern_out <= lut_pat;
            else if (!space_req) err         <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (code_q <= CODE_MAX_LETTER) begin
            shreg   <= pattern_out;
            key_out <= pattern_out[lead];
            idx     <= lead - 4'd1;
            last    <= 1'b0;
            state   <= ST_SEND;
          end
`ifdef MORSE_TX_WORD_GAP_EN
          else if (code_q == CODE_SPACE) begin
            key_out <= 1'b0;
            wcnt    <= 1'b0;
            state   <= ST_WORD;
          end
`endif
          else begin
            key_out <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        ST_SEND: begin
          if (last) begin
            key_out <= 1'b0;
            last    <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            key_out <= shreg[idx];
            idx     <= idx - 4'd1;
            last    <= (idx == 4'd0);
          end
        end
`ifdef MORSE_TX_WORD_GAP_EN
        ST_WORD: begin
          key_out <= 1'b0;
          if (wcnt) state <= ST_IDLE;
          else      wcnt  <= 1'b1;
        end
`endif
        default: begin
          key_out <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
